// File: rtl/halflife_if.sv
// Bus between the half-life sequencer, the user controls and the load/up/down counter.
// HALFLIFE_PAUSE_EN adds the pause control.
interface halflife_if #(
  parameter int N = 4
);
  logic         start;
  logic         abort;
  logic [N-1:0] init_val;
  logic [N-1:0] cnt_q;
`ifdef HALFLIFE_PAUSE_EN
  logic         pause;
`endif
  logic         cnt_load;
  logic         cnt_up;
  logic         cnt_down;
  logic [N-1:0] cnt_in;
  logic [N-1:0] period;
  logic [N-1:0] halvings;
  logic         busy;
  logic         done;

  modport master (
`ifdef HALFLIFE_PAUSE_EN
    input  pause,
`endif
    input  start, abort, init_val, cnt_q,
    output cnt_load, cnt_up, cnt_down, cnt_in, period, halvings, busy, done
  );

  modport slave (
`ifdef HALFLIFE_PAUSE_EN
    output pause,
`endif
    output start, abort, init_val, cnt_q,
    input  cnt_load, cnt_up, cnt_down, cnt_in, period, halvings, busy, done
  );
endinterface

// File: rtl/halflife_ctrl.sv
// Half-life timer sequencer: load period, count it down at the prescaled rate, halve, repeat.
// Optional feature macro: HALFLIFE_PAUSE_EN (adds a pause that freezes counting).
module halflife_ctrl #(
  parameter int N        = 4,
  parameter int TICK_DIV = 8
) (
  input  logic      clk,
  input  logic      rst,
  halflife_if.master bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COUNT = 3'd2,
    HALVE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [N-1:0]  period_q, period_d;
  logic [N-1:0]  halvings_q, halvings_d;
  logic [N-1:0]  cnt_in_q, cnt_in_d;
  logic          cnt_load_q, cnt_load_d;
  logic          cnt_down_q, cnt_down_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_hit;
  logic          advance;
  logic          pause_in;

`ifdef HALFLIFE_PAUSE_EN
  assign pause_in = bus.pause;
`else
  assign pause_in = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    period_d   = period_q;
    halvings_d = halvings_q;
    abort_hit  = 1'b0;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          halvings_d = '0;
          if (bus.init_val != '0) begin
            period_d = bus.init_val;
            state_d  = LOAD;
          end else begin
            period_d = '0;
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        presc_d = '0;
        state_d = COUNT;
      end
      COUNT: begin
        if (pause_in) begin
          state_d = COUNT;
        end else if (bus.cnt_q == '0) begin
          state_d = HALVE;
        end else begin
          advance = 1'b1;
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end
      end
      HALVE: begin
        period_d = period_q >> 1;
        if (halvings_q != {N{1'b1}}) begin
          halvings_d = halvings_q + N'(1);
        end else begin
          halvings_d = halvings_q;
        end
        state_d = ((period_q >> 1) == '0) ? DONE : LOAD;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition and freezes the run's bookkeeping.
    if (state_q != IDLE && bus.abort) begin
      abort_hit  = 1'b1;
      advance    = 1'b0;
      state_d    = IDLE;
      presc_d    = presc_q;
      period_d   = period_q;
      halvings_d = halvings_q;
    end else begin
      abort_hit  = 1'b0;
    end

    // Outputs are registered copies of the decode of the next state, so they line up with it.
    // cnt_q is stable one cycle ahead of a tick because ticks are never back to back.
    cnt_load_d = abort_hit || (state_d == LOAD);
    cnt_in_d   = (state_d == LOAD) ? period_d : '0;
    cnt_down_d = advance && (presc_d == PRESC_MAX) && (bus.cnt_q != '0);
    busy_d     = (state_d == LOAD) || (state_d == COUNT) || (state_d == HALVE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      period_q   <= '0;
      halvings_q <= '0;
      cnt_in_q   <= '0;
      cnt_load_q <= 1'b0;
      cnt_down_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      halvings_q <= halvings_d;
      cnt_in_q   <= cnt_in_d;
      cnt_load_q <= cnt_load_d;
      cnt_down_q <= cnt_down_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.cnt_load = cnt_load_q;
  assign bus.cnt_up   = 1'b0;
  assign bus.cnt_down = cnt_down_q;
  assign bus.cnt_in   = cnt_in_q;
  assign bus.period   = period_q;
  assign bus.halvings = halvings_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_halflife_ctrl.sv
// Bench for halflife_ctrl (N=4, TICK_DIV=2) with a load/up/down counter model attached.
// Expected run results and counter loads are queued at stimulus time and popped when the DUT produces them.
module tb_halflife_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   k;
  logic [3:0] cnt_model;
  logic [3:0] held;

  typedef struct {
    int halv;
    int per;
    int dcyc;
  } exp_t;

  exp_t sb[$];
  int   ldq[$];

  halflife_if #(.N(4)) bus_if ();

  halflife_ctrl #(.N(4), .TICK_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter model driven by the sequencer strobes.
  always @(posedge clk) begin
    if (rst) cnt_model <= 4'd0;
    else if (bus_if.cnt_load) cnt_model <= bus_if.cnt_in;
    else if (bus_if.cnt_up) cnt_model <= cnt_model + 4'd1;
    else if (bus_if.cnt_down) cnt_model <= cnt_model - 4'd1;
    else cnt_model <= cnt_model;
  end
  assign bus_if.cnt_q = cnt_model;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard side: compare each done pulse and each counter load against the queued expectation.
  always @(negedge clk) begin
    if (!rst && bus_if.done) begin
      if (sb.size() == 0) begin
        check_val("done_unexpected", int'(bus_if.done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("done_cycle", cyc, e.dcyc);
        check_val("done_halvings", int'(bus_if.halvings), e.halv);
        check_val("done_period", int'(bus_if.period), e.per);
      end
    end
    if (!rst && bus_if.cnt_load) begin
      if (ldq.size() == 0) check_val("load_unexpected", int'(bus_if.cnt_load), 0);
      else check_val("load_cnt_in", int'(bus_if.cnt_in), ldq.pop_front());
    end
  end

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && (sb.size() != 0 || ldq.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check_val("drain_sb", sb.size(), 0);
    check_val("drain_loads", ldq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    bus_if.start    = 1'b0;
    bus_if.abort    = 1'b0;
    bus_if.init_val = 4'd0;
`ifdef HALFLIFE_PAUSE_EN
    bus_if.pause    = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy", int'(bus_if.busy), 0);
    check_val("rst_done", int'(bus_if.done), 0);
    check_val("rst_load", int'(bus_if.cnt_load), 0);
    check_val("rst_up", int'(bus_if.cnt_up), 0);
    check_val("rst_down", int'(bus_if.cnt_down), 0);
    check_val("rst_cnt_in", int'(bus_if.cnt_in), 0);
    check_val("rst_period", int'(bus_if.period), 0);
    check_val("rst_halvings", int'(bus_if.halvings), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full run from 4: loads 4,2,1, done 23 cycles after LOAD entry.
    bus_if.init_val = 4'd4;
    bus_if.start    = 1'b1;
    sb.push_back('{3, 0, cyc + 24});
    ldq.push_back(4); ldq.push_back(2); ldq.push_back(1);
    @(negedge clk);
    bus_if.start = 1'b0;
    check_val("run4_busy_load", int'(bus_if.busy), 1);
    check_val("run4_period_load", int'(bus_if.period), 4);
    wait_drain(100);
    check_val("run4_busy_after", int'(bus_if.busy), 0);
    check_val("run4_up_after", int'(bus_if.cnt_up), 0);

    // Zero period: done next cycle, never busy, no load; clears previous halvings.
    bus_if.init_val = 4'd0;
    bus_if.start    = 1'b1;
    sb.push_back('{0, 0, cyc + 1});
    @(negedge clk);
    bus_if.start = 1'b0;
    check_val("zero_busy_done", int'(bus_if.busy), 0);
    @(negedge clk);
    check_val("zero_busy_after", int'(bus_if.busy), 0);
    wait_drain(10);

    // Abort while idle is ignored.
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check_val("idle_abort_busy", int'(bus_if.busy), 0);
    @(negedge clk);
    check_val("idle_abort_busy2", int'(bus_if.busy), 0);

    // Run from 15, abort on the 5th COUNT cycle.
    bus_if.init_val = 4'd15;
    bus_if.start    = 1'b1;
    ldq.push_back(15);
    k = cyc;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("abort_pre_busy", int'(bus_if.busy), 1);
    bus_if.abort = 1'b1;
    ldq.push_back(0);
    @(negedge clk);
    bus_if.abort = 1'b0;
    check_val("abort_cycle", cyc, k + 7);
    check_val("abort_load", int'(bus_if.cnt_load), 1);
    check_val("abort_down", int'(bus_if.cnt_down), 0);
    check_val("abort_busy", int'(bus_if.busy), 0);
    check_val("abort_done", int'(bus_if.done), 0);
    check_val("abort_halvings", int'(bus_if.halvings), 0);
    check_val("abort_period", int'(bus_if.period), 15);
    @(negedge clk);
    check_val("abort_load_after", int'(bus_if.cnt_load), 0);
    check_val("abort_busy_after", int'(bus_if.busy), 0);
    wait_drain(5);

    // Start pulsed mid-COUNT with a different value is ignored.
    bus_if.init_val = 4'd2;
    bus_if.start    = 1'b1;
    sb.push_back('{2, 0, cyc + 13});
    ldq.push_back(2); ldq.push_back(1);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.init_val = 4'd9;
    bus_if.start    = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check_val("restart_period", int'(bus_if.period), 2);
    check_val("restart_busy", int'(bus_if.busy), 1);
    wait_drain(60);

`ifdef HALFLIFE_PAUSE_EN
    // Ten paused cycles inside COUNT delay done by exactly ten cycles.
    bus_if.init_val = 4'd2;
    bus_if.start    = 1'b1;
    sb.push_back('{2, 0, cyc + 23});
    ldq.push_back(2); ldq.push_back(1);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.pause = 1'b1;
    repeat (2) @(negedge clk);
    held = cnt_model;
    repeat (8) @(negedge clk);
    check_val("pause_cnt_frozen", int'(cnt_model), int'(held));
    check_val("pause_down", int'(bus_if.cnt_down), 0);
    check_val("pause_busy", int'(bus_if.busy), 1);
    bus_if.pause = 1'b0;
    wait_drain(80);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
